blink_fader: RTL
================

Name: blink_fader

Overview:
- Downstream consumer of the blink generator's `led`/`flg` outputs.
- Converts the hard on/off `led` level into a smooth PWM fade-in/fade-out.
- A brightness level ramps toward the `led` target at a fixed step rate and drives a registered PWM output to the physical LED pin.
- Optionally phase-aligns the PWM frame to the generator's `flg` wrap strobe.

Parameters:
- PBITS, 8, PWM/brightness resolution in bits; MAX = 2^PBITS-1; legal 2..16.
- STEP_DIV, 256, clock cycles per brightness step; legal >= 1.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- led_in  input  1  target level from the blink generator (1 = on).
- flg_in  input  1  one-cycle wrap strobe from the blink generator.
- pwm_out  output  1  registered PWM drive to the LED pin.
- level  output  PBITS  current brightness, 0..MAX.
- busy  output  1  high while ramping (state UP or DOWN).

Behaviour:
- Reset (rst=1 at posedge): state=OFF, level=0, pcnt=0, scnt=0, led_q=0, pwm_out=0, busy=0.
  - Applies on the same edge regardless of state, including mid-ramp.
  - rst has priority over every other input.
- Input register: led_q <= led_in every cycle. The FSM uses only led_q, never led_in.
- PWM counter pcnt (PBITS wide):
  - Counts 0..MAX-1, then wraps to 0. Period is MAX cycles.
  - pwm_out <= (pcnt < level), registered, so it shows one cycle of latency from level.
  - level=0 gives pwm_out constantly 0; level=MAX gives pwm_out constantly 1.
- Step prescaler scnt (clog2(STEP_DIV) bits, minimum 1 bit):
  - Counts 0..STEP_DIV-1; step = (scnt == STEP_DIV-1); wraps to 0.
  - Cleared to 0 on every entry into UP or DOWN, including reversals.
  - First step therefore fires exactly STEP_DIV cycles after entry.
  - STEP_DIV=1 means a step every cycle.
- FSM states: OFF, UP, ON, DOWN.
  - OFF: level=0. If led_q then go to UP.
  - UP: on step, level <= level+1; if level+1 == MAX, go to ON on the same edge. If !led_q then go to DOWN (level unchanged on that edge, scnt cleared). Reversal has priority over a coincident step.
  - ON: level=MAX. If !led_q then go to DOWN.
  - DOWN: on step, level <= level-1; if level-1 == 0, go to OFF on the same edge. If led_q then go to UP (priority over a coincident step).
- level never wraps: no increment at MAX, no decrement at 0.
- busy is registered and equals (next state is UP or DOWN).
- Latency:
  - led_in change at edge T is captured in led_q at T+1.
  - The state change happens at T+2.
  - The first level change happens at T+2+STEP_DIV.
  - A full ramp 0 to MAX takes MAX*STEP_DIV cycles after entry into UP.
- Unsupported: flg_in pulses longer than one cycle (behaviour stays defined but is untested). led_in glitches shorter than one cycle are not filtered.

Optional Feature:
- Macro: BLINK_FADER_FLG_SYNC_EN.
- Defined:
  - flg_in=1 at a posedge (rst=0) sets pcnt <= 0, overriding the normal increment/wrap, so each blink wrap starts a fresh PWM frame.
  - pwm_out is still computed from the pre-update pcnt on that edge.
  - FSM, level and scnt are unaffected.
- Undefined: flg_in is ignored entirely (port remains, unused) and pcnt free-runs.

Test Plan (PBITS=4 so MAX=15; STEP_DIV=4 unless noted):
- Reset: rst=1 for 2 cycles with led_in=1 -> level=0, pwm_out=0, busy=0, state OFF; after release, UP is entered 2 edges later.
- Fade-in: led_in 0->1 at edge T -> busy=1 from T+2; level=1 at T+6, level=15 at T+62 with state ON and busy=0 on the same edge; pwm_out=1 continuously from T+63 for 30 cycles.
- Reversal: in UP at level=7, drop led_in -> state DOWN 2 edges later with level still 7; level reaches 0 exactly 28 cycles after DOWN entry; state OFF, busy=0, pwm_out=0 one cycle later.
- Duty: STEP_DIV=64, hold level=5 -> every aligned 15-cycle pwm_out window contains exactly 5 high cycles; level=0 gives 0 high cycles, level=15 gives 15.
- Reset mid-ramp: rst=1 while in DOWN at level=9 -> next edge level=0, OFF, busy=0, pcnt=0, and scnt=0 (observed via the next ramp taking exactly 4 cycles to its first step).
- Flag sync: with BLINK_FADER_FLG_SYNC_EN, flg_in pulse when pcnt=10 -> pcnt=0 on the next edge and the frame restarts. Without the macro -> pcnt=11, no effect.

Source files
------------

// File: rtl/blink_fader.sv
`default_nettype none
// ============================================================================
// blink_fader: ramps the blink generator's led level into a smooth PWM fade.
// Optional: define BLINK_FADER_FLG_SYNC_EN to restart the PWM frame on flg_in.
// Revision: 1.0
// ============================================================================
module blink_fader #(
  parameter int PBITS    = 8,
  parameter int STEP_DIV = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  input  logic             flg_in,
  output logic             pwm_out,
  output logic [PBITS-1:0] level,
  output logic             busy
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PBITS-1:0] C_MAX       = {PBITS{1'b1}};
  localparam logic [PBITS-1:0] C_PWM_LAST  = C_MAX - 1'b1;
  localparam logic [PBITS-1:0] C_ONE       = {{(PBITS-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    C_STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PBITS-1:0] level_q, level_d;
  logic [PBITS-1:0] pcnt_q, pcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic             led_q;
  logic             pwm_q;
  logic             busy_q;
  logic             step;

  assign step = (scnt_q == C_STEP_LAST);

`ifdef BLINK_FADER_FLG_SYNC_EN
  always_comb begin
    pcnt_d = (pcnt_q == C_PWM_LAST) ? '0 : pcnt_q + 1'b1;
    if (flg_in) pcnt_d = '0;
  end
`else
  logic unused_flg;
  assign unused_flg = flg_in;

  always_comb begin
    pcnt_d = (pcnt_q == C_PWM_LAST) ? '0 : pcnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    scnt_d  = step ? '0 : scnt_q + 1'b1;
    case (state_q)
      ST_OFF: begin
        level_d = '0;
        if (led_q) begin
          state_d = ST_UP;
          scnt_d  = '0;
        end
      end
      ST_UP: begin
        // A reversal wins over a step landing on the same edge.
        if (!led_q) begin
          state_d = ST_DOWN;
          scnt_d  = '0;
        end else if (step && level_q != C_MAX) begin
          level_d = level_q + 1'b1;
          if (level_q == C_PWM_LAST) state_d = ST_ON;
        end
      end
      ST_ON: begin
        level_d = C_MAX;
        if (!led_q) begin
          state_d = ST_DOWN;
          scnt_d  = '0;
        end
      end
      ST_DOWN: begin
        if (led_q) begin
          state_d = ST_UP;
          scnt_d  = '0;
        end else if (step) begin
          // A reversal out of UP at level 0 lands here; leave without wrapping.
          if (level_q != '0) level_d = level_q - 1'b1;
          if (level_q == C_ONE || level_q == '0) state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      level_q <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      led_q   <= 1'b0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      led_q   <= led_in;
      pcnt_q  <= pcnt_d;
      pwm_q   <= (pcnt_q < level_q);
      state_q <= state_d;
      level_q <= level_d;
      scnt_q  <= scnt_d;
      busy_q  <= (state_d == ST_UP) || (state_d == ST_DOWN);
    end
  end

  assign pwm_out = pwm_q;
  assign level   = level_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire
